// File: rtl/execute_m_pipe_pkg.sv
// Shared types for the memory execute pipe: issue, bypass, LSQ and stage packets.
// ISSUE_WIDTH sets the default bypass channel count when not supplied by the build.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif

package execute_m_pipe_pkg;

    localparam int SIZE_DATA         = 32;
    localparam int SIZE_PC           = 32;
    localparam int SIZE_INST         = 32;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int SIZE_SEQ          = 8;
    localparam int SIZE_LSQ_LOG      = 4;
    localparam int SIZE_AL_LOG       = 5;

    localparam logic [1:0] LDST_BYTE        = 2'b00;
    localparam logic [1:0] LDST_HALF_WORD   = 2'b01;
    localparam logic [1:0] LDST_WORD        = 2'b10;
    localparam logic [1:0] LDST_DOUBLE_WORD = 2'b11;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic isLoad;
        logic isStore;
        logic isUnsigned;
    } exeFlgs;

    typedef struct packed {
        logic                         valid;
        logic [SIZE_SEQ-1:0]          seqNo;
        logic [SIZE_PC-1:0]           pc;
        logic [SIZE_INST-1:0]         inst;
        logic [SIZE_DATA-1:0]         immed;
        logic [SIZE_PHYSICAL_LOG-1:0] phySrc1;
        logic [SIZE_DATA-1:0]         src1Data;
        logic [SIZE_PHYSICAL_LOG-1:0] phySrc2;
        logic [SIZE_DATA-1:0]         src2Data;
        logic [SIZE_PHYSICAL_LOG-1:0] phyDest;
        logic [SIZE_LSQ_LOG-1:0]      lsqID;
        logic [SIZE_AL_LOG-1:0]       alID;
        logic                         isAtom;
        logic [4:0]                   amo_op;
    } fuPkt;

    typedef struct packed {
        logic                         valid;
        logic [SIZE_PHYSICAL_LOG-1:0] tag;
        logic [SIZE_DATA-1:0]         data;
    } bypassPkt;

    typedef struct packed {
        logic                         valid;
        logic [SIZE_SEQ-1:0]          seqNo;
        logic [SIZE_PC-1:0]           pc;
        logic [SIZE_DATA-1:0]         address;
        logic [1:0]                   ldstSize;
        exeFlgs                       flags;
        logic [SIZE_PHYSICAL_LOG-1:0] phyDest;
        logic [SIZE_DATA-1:0]         src2Data;
        logic [SIZE_LSQ_LOG-1:0]      lsqID;
        logic [SIZE_AL_LOG-1:0]       alID;
        logic                         isAtom;
        logic [4:0]                   amo_op;
    } memPkt;

    typedef struct packed {
        memPkt pkt;
        logic  misalign;
    } memStagePkt;

    function automatic logic is_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size);
        logic r;
        r = 1'b0;
        case (size)
            LDST_HALF_WORD:   r = addr_lo[0];
            LDST_WORD:        r = |addr_lo[1:0];
            LDST_DOUBLE_WORD: r = |addr_lo;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/AGEN_ALU.sv
// Address generation: base + immediate, access size and load/store flags
// decoded from the instruction word.
module AGEN_ALU
    import execute_m_pipe_pkg::*;
(
    input  logic [SIZE_DATA-1:0] src1Data_i,
    input  logic [SIZE_DATA-1:0] immed_i,
    input  logic [SIZE_INST-1:0] inst_i,
    output logic [SIZE_DATA-1:0] address_o,
    output logic [1:0]           ldstSize_o,
    output exeFlgs               flags_o
);

    logic unused_inst;
    assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

    always_comb begin
        address_o          = src1Data_i + immed_i;
        ldstSize_o         = inst_i[13:12];
        flags_o            = '0;
        flags_o.isLoad     = (inst_i[6:0] == OPC_LOAD);
        flags_o.isStore    = (inst_i[6:0] == OPC_STORE);
        flags_o.isUnsigned = inst_i[14];
    end

endmodule

// File: rtl/ForwardCheck.sv
// Operand bypass: replaces register data with the first valid channel
// whose tag matches; lowest channel index wins.
module ForwardCheck
    import execute_m_pipe_pkg::*;
#(
    parameter int BYPASS_NUM = `ISSUE_WIDTH
) (
    input  logic [SIZE_PHYSICAL_LOG-1:0] srcReg_i,
    input  logic [SIZE_DATA-1:0]         srcData_i,
    input  bypassPkt                     bypassPacket_i [0:BYPASS_NUM-1],
    output logic [SIZE_DATA-1:0]         dataOut_o
);

    always_comb begin
        dataOut_o = srcData_i;
        for (int i = BYPASS_NUM - 1; i >= 0; i--) begin
            if (bypassPacket_i[i].valid && bypassPacket_i[i].tag == srcReg_i) begin
                dataOut_o = bypassPacket_i[i].data;
            end
        end
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// Bubble-collapsing register pipeline of PIPE_DEPTH stages with a
// valid/ready output; valid bits are reset, payload is not.
module mem_stage_pipe
    import execute_m_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              flush_i,
    input  memStagePkt                        in_i,
    output logic                              ready_o,
    input  logic                              lsqReady_i,
    output memStagePkt                        out_o,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(PIPE_DEPTH + 1);

    logic [PIPE_DEPTH-1:0] valid_q, valid_d, adv;
    memStagePkt            data_q [PIPE_DEPTH];
    memStagePkt            data_d [PIPE_DEPTH];
    logic                  go;
    logic                  accept;

    // adv[k]: stage k may move on this edge (downstream slot frees up)
    always_comb begin
        adv = '0;
        go  = lsqReady_i;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            adv[k] = go;
            go     = !valid_q[k] || go;
        end
        ready_o = go;
    end

    assign accept = in_i.pkt.valid && ready_o && !flush_i;

    always_comb begin
        valid_d = valid_q & ~adv;
        data_d  = data_q;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if (valid_q[k-1] && adv[k-1]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = data_q[k-1];
            end
        end
        if (accept) begin
            valid_d[0] = 1'b1;
            data_d[0]  = in_i;
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    logic unused_last_valid;
    assign unused_last_valid = data_q[PIPE_DEPTH-1].pkt.valid;

    always_comb begin
        out_o           = data_q[PIPE_DEPTH-1];
        out_o.pkt.valid = valid_q[PIPE_DEPTH-1] && !flush_i;
    end

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            occupancy_o = occupancy_o + OCC_W'(valid_q[k]);
        end
    end

endmodule

// File: rtl/execute_m_pipe.sv
// Memory execute pipe: bypass, address generation and a registered AGEN pipeline to the LSQ.
// Define AGEN_MISALIGN_CHECK_EN to build the address misalignment flag.
module execute_m_pipe
    import execute_m_pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = 2,
    parameter int BYPASS_NUM = `ISSUE_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush_i,
    input  fuPkt                            exePacket_i,
    input  bypassPkt                        bypassPacket_i [0:BYPASS_NUM-1],
    output logic                            exeReady_o,
    input  logic                            lsqReady_i,
    output memPkt                           memPacket_o,
    output logic                            misalign_o,
    output logic [$clog2(PIPE_DEPTH+1)-1:0] occupancy_o
);

    logic [SIZE_DATA-1:0] src1_fwd, src2_fwd, address;
    logic [1:0]           ldst_size;
    exeFlgs               flags;
    memStagePkt           stage_in, stage_out;

    ForwardCheck #(.BYPASS_NUM(BYPASS_NUM)) u_fwd_src1 (
        .srcReg_i       (exePacket_i.phySrc1),
        .srcData_i      (exePacket_i.src1Data),
        .bypassPacket_i (bypassPacket_i),
        .dataOut_o      (src1_fwd)
    );

    ForwardCheck #(.BYPASS_NUM(BYPASS_NUM)) u_fwd_src2 (
        .srcReg_i       (exePacket_i.phySrc2),
        .srcData_i      (exePacket_i.src2Data),
        .bypassPacket_i (bypassPacket_i),
        .dataOut_o      (src2_fwd)
    );

    AGEN_ALU u_agen (
        .src1Data_i (src1_fwd),
        .immed_i    (exePacket_i.immed),
        .inst_i     (exePacket_i.inst),
        .address_o  (address),
        .ldstSize_o (ldst_size),
        .flags_o    (flags)
    );

    always_comb begin
        stage_in              = '0;
        stage_in.pkt.valid    = exePacket_i.valid;
        stage_in.pkt.seqNo    = exePacket_i.seqNo;
        stage_in.pkt.pc       = exePacket_i.pc;
        stage_in.pkt.address  = address;
        stage_in.pkt.ldstSize = ldst_size;
        stage_in.pkt.flags    = flags;
        stage_in.pkt.phyDest  = exePacket_i.phyDest;
        stage_in.pkt.src2Data = src2_fwd;
        stage_in.pkt.lsqID    = exePacket_i.lsqID;
        stage_in.pkt.alID     = exePacket_i.alID;
        stage_in.pkt.isAtom   = exePacket_i.isAtom;
        stage_in.pkt.amo_op   = exePacket_i.amo_op;
`ifdef AGEN_MISALIGN_CHECK_EN
        stage_in.misalign     = is_misaligned(address[2:0], ldst_size);
`endif
    end

    mem_stage_pipe #(.PIPE_DEPTH(PIPE_DEPTH)) u_stages (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (flush_i),
        .in_i        (stage_in),
        .ready_o     (exeReady_o),
        .lsqReady_i  (lsqReady_i),
        .out_o       (stage_out),
        .occupancy_o (occupancy_o)
    );

    assign memPacket_o = stage_out.pkt;

`ifdef AGEN_MISALIGN_CHECK_EN
    assign misalign_o = stage_out.pkt.valid && stage_out.misalign;
`else
    logic unused_misalign;
    assign unused_misalign = stage_out.misalign;
    assign misalign_o      = 1'b0;
`endif

endmodule

// File: tb/tb_execute_m_pipe.sv
// Directed bench for execute_m_pipe at PIPE_DEPTH=2: latency, bypass,
// back-pressure, flush, misalignment and asynchronous reset.
module tb_execute_m_pipe;
    import execute_m_pipe_pkg::*;

    localparam int BN = `ISSUE_WIDTH;
    localparam int PD = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       lsq;
    fuPkt       exe;
    bypassPkt   byp [0:BN-1];
    logic       rdy;
    memPkt      mem;
    logic       mis;
    logic [1:0] occ;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    execute_m_pipe #(.PIPE_DEPTH(PD), .BYPASS_NUM(BN)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush_i        (flush),
        .exePacket_i    (exe),
        .bypassPacket_i (byp),
        .exeReady_o     (rdy),
        .lsqReady_i     (lsq),
        .memPacket_o    (mem),
        .misalign_o     (mis),
        .occupancy_o    (occ)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic fuPkt mk_op(input logic [7:0] seq, input logic [6:0] t1,
                                   input logic [31:0] d1, input logic [31:0] imm,
                                   input logic [1:0] sz);
        fuPkt p;
        p          = '0;
        p.valid    = 1'b1;
        p.seqNo    = seq;
        p.pc       = 32'h8000_0000 + {22'd0, seq, 2'b00};
        p.inst     = {17'd0, 1'b0, sz, 5'd3, OPC_LOAD};
        p.immed    = imm;
        p.phySrc1  = t1;
        p.src1Data = d1;
        p.phySrc2  = 7'h7f;
        p.src2Data = 32'h5555_5555;
        p.phyDest  = 7'd3;
        p.lsqID    = seq[3:0];
        p.alID     = seq[4:0];
        return p;
    endfunction

    int   issued;
    int   out_cnt;
    logic pend;
    logic [31:0] m_addr [4];
    logic [1:0]  m_size [4];
    logic        m_exp  [4];

    initial begin
        exe     = '0;
        flush   = 1'b0;
        lsq     = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < BN; i++) byp[i] = '0;

        // reset state
        #2;
        check("rst_valid", 32'(mem.valid), 32'd0);
        check("rst_misalign", 32'(mis), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // four back-to-back loads, lsqReady high
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            exe = (c < 4) ? mk_op(8'(c), 7'h01, 32'h100, 32'(4 * c), LDST_WORD) : '0;
            #1;
            check("b2b_valid", 32'(mem.valid), 32'((c >= 2) && (c <= 5)));
            if (c < 4) check("b2b_ready", 32'(rdy), 32'd1);
            if ((c >= 2) && (c <= 5)) begin
                check("b2b_addr", mem.address, 32'h100 + 32'(4 * (c - 2)));
                check("b2b_seq", 32'(mem.seqNo), 32'(c - 2));
            end
            if (c == 3) check("b2b_occ", 32'(occ), 32'd2);
        end

        // bypass: src1 tag 0x12 on channel 1, src2 tag 0x20 on channel 3
        tick();
        byp[0] = '{valid: 1'b1, tag: 7'h11, data: 32'hBAD0};
        byp[1] = '{valid: 1'b1, tag: 7'h12, data: 32'h1000};
        byp[2] = '{valid: 1'b0, tag: 7'h12, data: 32'hFFFF};
        byp[3] = '{valid: 1'b1, tag: 7'h20, data: 32'hCAFE};
        exe = mk_op(8'h40, 7'h12, 32'hDEAD_0000, 32'd8, LDST_WORD);
        exe.phySrc2 = 7'h20;
        tick();
        exe = '0;
        for (int i = 0; i < BN; i++) byp[i] = '0;
        tick();
        check("byp_valid", 32'(mem.valid), 32'd1);
        check("byp_addr", mem.address, 32'h1008);
        check("byp_src2", mem.src2Data, 32'hCAFE);
        check("byp_size", 32'(mem.ldstSize), 32'(LDST_WORD));
        check("byp_isload", 32'(mem.flags.isLoad), 32'd1);
        tick();
        check("byp_drain", 32'(mem.valid), 32'd0);

        // back-pressure for five cycles with continuous issue
        issued = 0;
        out_cnt = 0;
        pend = 1'b0;
        lsq = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            if (pend) issued++;
            #1;
            exe = (issued < 5) ? mk_op(8'(10 + issued), 7'h01, 32'h2000,
                                       32'(4 * issued), LDST_WORD) : '0;
            #1;
            pend = rdy && exe.valid;
            if (c >= 2) begin
                check("stall_occ", 32'(occ), 32'd2);
                check("stall_ready", 32'(rdy), 32'd0);
                check("stall_valid", 32'(mem.valid), 32'd1);
                check("stall_seq", 32'(mem.seqNo), 32'd10);
                check("stall_addr", mem.address, 32'h2000);
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            if (pend) issued++;
            #1;
            lsq = 1'b1;
            exe = (issued < 5) ? mk_op(8'(10 + issued), 7'h01, 32'h2000,
                                       32'(4 * issued), LDST_WORD) : '0;
            #1;
            pend = rdy && exe.valid;
            if (mem.valid) begin
                check("release_seq", 32'(mem.seqNo), 32'(10 + out_cnt));
                check("release_addr", mem.address, 32'h2000 + 32'(4 * out_cnt));
                out_cnt++;
            end
        end
        exe = '0;
        check("release_issued", 32'(issued), 32'd5);
        check("release_count", 32'(out_cnt), 32'd5);

        // flush with two ops in flight and one presented
        tick();
        exe = mk_op(8'h50, 7'h01, 32'h3000, 32'd0, LDST_WORD);
        tick();
        exe = mk_op(8'h51, 7'h01, 32'h3000, 32'd4, LDST_WORD);
        tick();
        exe = mk_op(8'h52, 7'h01, 32'h3000, 32'd8, LDST_WORD);
        flush = 1'b1;
        #1;
        check("flush_occ_before", 32'(occ), 32'd2);
        check("flush_out_suppressed", 32'(mem.valid), 32'd0);
        tick();
        exe = '0;
        flush = 1'b0;
        #1;
        check("flush_occ_after", 32'(occ), 32'd0);
        check("flush_valid_after", 32'(mem.valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("flush_no_output", 32'(mem.valid), 32'd0);
        end

        // misalignment flag
        m_addr[0] = 32'h1002; m_size[0] = LDST_WORD;      m_exp[0] = 1'b1;
        m_addr[1] = 32'h1004; m_size[1] = LDST_WORD;      m_exp[1] = 1'b0;
        m_addr[2] = 32'h1001; m_size[2] = LDST_HALF_WORD; m_exp[2] = 1'b1;
        m_addr[3] = 32'h1003; m_size[3] = LDST_BYTE;      m_exp[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exe = mk_op(8'(8'h60 + i), 7'h01, 32'h1000, m_addr[i] - 32'h1000, m_size[i]);
            tick();
            exe = '0;
            tick();
            check("mis_valid", 32'(mem.valid), 32'd1);
            check("mis_addr", mem.address, m_addr[i]);
`ifdef AGEN_MISALIGN_CHECK_EN
            check("mis_flag", 32'(mis), 32'(m_exp[i]));
`else
            check("mis_flag_off", 32'(mis), 32'd0);
`endif
        end
        tick();
        check("mis_idle", 32'(mis), 32'd0);

        // asynchronous reset in the middle of a stalled stream
        lsq = 1'b0;
        tick();
        exe = mk_op(8'h70, 7'h01, 32'h4002, 32'd0, LDST_WORD);
        tick();
        exe = mk_op(8'h71, 7'h01, 32'h4000, 32'd4, LDST_WORD);
        tick();
        exe = '0;
        #1;
        check("prerst_occ", 32'(occ), 32'd2);
        check("prerst_valid", 32'(mem.valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(mem.valid), 32'd0);
        check("midrst_occ", 32'(occ), 32'd0);
        check("midrst_misalign", 32'(mis), 32'd0);
        check("midrst_ready", 32'(rdy), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        lsq = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("postrst_ready", 32'(rdy), 32'd1);
            check("postrst_valid", 32'(mem.valid), 32'd0);
            check("postrst_occ", 32'(occ), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_m_pipe.md
EXECUTE_M_PIPE -- requirements
Module: execute_m_pipe

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 2, number of registered AGEN stages (legal 1..4).
REQ-002 SHALL have parameter BYPASS_NUM, default `ISSUE_WIDTH, number of bypass channels checked.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_i  input  1  recovery flush, kills all in-flight ops.
REQ-006 SHALL have port exePacket_i  input  fuPkt  issued memory op; valid field qualifies it.
REQ-007 SHALL have port bypassPacket_i  input  bypassPkt[0:BYPASS_NUM-1]  forwarding results.
REQ-008 SHALL have port exeReady_o  input-side ready  output  1  stage 0 can accept.
REQ-009 SHALL have port lsqReady_i  input  1  LSQ accepts memPacket_o this cycle.
REQ-010 SHALL have port memPacket_o  output  memPkt  LSQ packet; valid field qualifies it.
REQ-011 SHALL have port misalign_o  output  1  memPacket_o address not aligned to ldstSize.
REQ-012 SHALL have port occupancy_o  output  $clog2(PIPE_DEPTH+1)  count of valid stages.

Function
REQ-013 SHALL forward src1/src2 data from bypassPacket_i on physical-tag match, else use packet data, combinationally before stage 0.
REQ-014 SHALL compute address, ldstSize, flags from forwarded data, immed, inst, and capture them with seqNo, pc, phyDest, src2Data, lsqID, alID, isAtom, amo_op into stage 0.
REQ-015 SHALL accept an op when exePacket_i.valid && exeReady_o at a rising edge.
REQ-016 SHALL advance stage k into k+1 when k+1 is empty or k+1 advances (bubble-collapsing).
REQ-017 SHALL drive memPacket_o from the last stage; handshake completes when memPacket_o.valid && lsqReady_i.
REQ-018 SHALL hold memPacket_o stable while valid && !lsqReady_i.
REQ-019 SHALL assert exeReady_o combinationally = stage 0 empty or stage 0 advancing this cycle.
REQ-020 SHALL give latency of exactly PIPE_DEPTH cycles from accept to memPacket_o.valid when lsqReady_i stays high.
REQ-021 SHALL sustain one op per cycle with no bubbles when lsqReady_i stays high.
REQ-022 SHALL on flush_i clear every stage valid bit at the next edge, drop any same-cycle input, and suppress the same-cycle output handshake.
REQ-023 SHALL keep occupancy_o equal to the number of valid stages, updated every edge, never exceeding PIPE_DEPTH.
REQ-024 SHALL deassert exeReady_o when all PIPE_DEPTH stages are valid and lsqReady_i is low (full).

Reset
REQ-025 SHALL on reset_n low asynchronously clear all stage valid bits, memPacket_o.valid=0, misalign_o=0, occupancy_o=0, exeReady_o=1.
REQ-026 SHALL discard in-flight ops when reset asserts mid-operation; payload registers need no reset.

Configuration
REQ-027 SHALL compile misalignment detection when AGEN_MISALIGN_CHECK_EN is defined: misalign_o=1 when address low log2(size) bits nonzero for a valid last stage, registered with the op in stage 0.
REQ-028 SHALL, without AGEN_MISALIGN_CHECK_EN, tie misalign_o to 0 and instantiate no check logic.

Structure
REQ-029 SHALL use fuPkt, memPkt, bypassPkt, exeFlgs and LDST size encodings from the shared package; SHALL add a memStagePkt stage typedef there.
REQ-030 SHALL instantiate the existing ForwardCheck twice and AGEN_ALU once; the stage pipeline SHALL be one sub-module mem_stage_pipe.

Verification
REQ-031 SHALL cover: PIPE_DEPTH=2, lsqReady_i=1, 4 back-to-back loads -> memPacket_o.valid cycles 2..5, addresses in order.
REQ-032 SHALL cover: src1 tag 0x12 matches bypass channel 1 data 0x1000, immed 8 -> address 0x1008.
REQ-033 SHALL cover: lsqReady_i=0 for 5 cycles with continuous issue -> occupancy_o=2, exeReady_o=0, output held; release -> no op lost or duplicated.
REQ-034 SHALL cover: flush_i with 2 ops in flight and 1 input -> next cycle occupancy_o=0, no memPacket_o.valid.
REQ-035 SHALL cover: AGEN_MISALIGN_CHECK_EN defined, 4-byte load at 0x1002 -> misalign_o=1; at 0x1004 -> 0; macro undefined -> always 0.
REQ-036 SHALL cover: reset_n low mid-stream -> all valids 0 immediately, exeReady_o=1 after release.
